// File: rtl/charge_refresh_ctrl.sv
// rtl/charge_refresh_ctrl.sv - refresh scheduler and host arbiter for a bank of decaying charge cells
module charge_refresh_ctrl #(
    parameter int NUM_CELLS   = 4,
    parameter int DATA_W      = 8,
    parameter int DECAY_CYC   = 64,
    parameter int REFRESH_INT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         refresh_en,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [$clog2(NUM_CELLS)-1:0] req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [NUM_CELLS-1:0]         cell_valid,
    output logic                         decay_event,
    output logic                         refresh_overrun
);

    localparam int AW    = $clog2(NUM_CELLS);
    localparam int AGE_W = $clog2(DECAY_CYC);
    localparam int CNT_W = $clog2(REFRESH_INT + 1);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_ACCESS      = 2'd1,
        S_REF_SENSE   = 2'd2,
        S_REF_RESTORE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0]    cell_data [NUM_CELLS];
    logic [AGE_W-1:0]     cell_age  [NUM_CELLS];
    logic [AW-1:0]        ref_ptr;
    logic [AW-1:0]        lat_addr;
    logic                 lat_we;
    logic [DATA_W-1:0]    lat_wdata;
    logic [CNT_W-1:0]     int_cnt;
    logic                 refresh_pending;
    logic                 host_turn;
    logic                 req_seen;

    logic                 ref_wins;
    logic                 accept;
    logic                 wrap;
    logic                 rd_err;
    logic [NUM_CELLS-1:0] wr_hit;
    logic [NUM_CELLS-1:0] rs_hit;
    logic [NUM_CELLS-1:0] decay_now;

    // A pending refresh yields only to the one host access owed after the previous refresh.
    assign ref_wins = refresh_pending && !(host_turn && req_valid);
    assign accept   = (state == S_IDLE) && !ref_wins && req_valid;
    assign wrap     = refresh_en && (int_cnt == CNT_W'(REFRESH_INT - 1));

    // A write or restore landing on the decay edge keeps the cell alive.
    always_comb begin
        wr_hit    = '0;
        rs_hit    = '0;
        decay_now = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            wr_hit[i]    = (state == S_ACCESS) && lat_we && (lat_addr == AW'(i));
            rs_hit[i]    = (state == S_REF_RESTORE) && (ref_ptr == AW'(i)) && cell_valid[i];
            decay_now[i] = cell_valid[i] && (cell_age[i] == AGE_W'(DECAY_CYC - 1))
                           && !wr_hit[i] && !rs_hit[i];
        end
    end

    assign rd_err = !cell_valid[lat_addr] || decay_now[lat_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ref_wins) begin
                    state_nxt = S_REF_SENSE;
                end else if (req_valid) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS:      state_nxt = S_IDLE;
            S_REF_SENSE:   state_nxt = S_REF_RESTORE;
            S_REF_RESTORE: state_nxt = S_IDLE;
            default:       state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = !rst && (state == S_IDLE) && !ref_wins;
        decay_event = !rst && (|decay_now);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            int_cnt         <= '0;
            refresh_pending <= 1'b0;
            refresh_overrun <= 1'b0;
            host_turn       <= 1'b0;
            req_seen        <= 1'b0;
            ref_ptr         <= '0;
            lat_addr        <= '0;
            lat_we          <= 1'b0;
            lat_wdata       <= '0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
        end else begin
            if (refresh_en) begin
                int_cnt <= wrap ? '0 : int_cnt + CNT_W'(1);
            end
            // A new slot coming due outranks clearing the one being entered.
            if (wrap) begin
                refresh_pending <= 1'b1;
                if (refresh_pending) begin
                    refresh_overrun <= 1'b1;
                end
            end else if ((state == S_IDLE) && ref_wins) begin
                refresh_pending <= 1'b0;
            end

            if ((state == S_IDLE) && ref_wins) begin
                req_seen <= req_valid;
            end else if (state == S_REF_SENSE) begin
                req_seen <= req_seen || req_valid;
            end

            if (accept) begin
                lat_addr  <= req_addr;
                lat_we    <= req_we;
                lat_wdata <= req_wdata;
                host_turn <= 1'b0;
            end else if (state == S_REF_RESTORE) begin
                host_turn <= req_seen || req_valid;
                ref_ptr   <= ref_ptr + AW'(1);
            end

            rsp_valid <= (state == S_ACCESS);
            if (state == S_ACCESS) begin
                if (lat_we) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end else begin
                    rsp_rdata <= rd_err ? '0 : cell_data[lat_addr];
                    rsp_err   <= rd_err;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (rst) begin
                cell_data[i]  <= '0;
                cell_age[i]   <= '0;
                cell_valid[i] <= 1'b0;
            end else if (wr_hit[i]) begin
                cell_data[i]  <= lat_wdata;
                cell_age[i]   <= '0;
                cell_valid[i] <= 1'b1;
            end else if (rs_hit[i]) begin
                cell_age[i]   <= '0;
            end else if (decay_now[i]) begin
                cell_data[i]  <= '0;
                cell_age[i]   <= '0;
                cell_valid[i] <= 1'b0;
            end else if (cell_valid[i]) begin
                cell_age[i]   <= cell_age[i] + AGE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_charge_refresh_ctrl.sv
// tb/tb_charge_refresh_ctrl.sv - scoreboard bench for charge_refresh_ctrl
module tb_charge_refresh_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       refresh_en = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [1:0] req_addr = 2'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [3:0] cell_valid;
    logic       decay_event;
    logic       refresh_overrun;

    typedef struct {
        logic [7:0] rd;
        logic       err;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         decay_cnt = 0;
    int         last_decay_cyc = -1;
    int         ptr_adv = 0;
    logic [1:0] ptr_prev = 2'd0;
    logic [1:0] ptr_exp;

    charge_refresh_ctrl #(
        .NUM_CELLS(4), .DATA_W(8), .DECAY_CYC(64), .REFRESH_INT(8)
    ) dut (
        .clk(clk), .rst(rst), .refresh_en(refresh_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cell_valid(cell_valid), .decay_event(decay_event),
        .refresh_overrun(refresh_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Response monitor, decay counter and refresh pointer order tracker.
    always @(negedge clk) begin
        if (rst) begin
            ptr_prev = 2'd0;
        end else begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rd));
                    chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                    chk("rsp_latency_cycle", 32'(cyc), 32'(mon_e.due));
                end
            end
            if (decay_event) begin
                decay_cnt++;
                last_decay_cyc = cyc;
            end
            if (dut.ref_ptr != ptr_prev) begin
                ptr_exp = ptr_prev + 2'd1;
                chk("refresh_ptr_order", 32'(dut.ref_ptr), 32'(ptr_exp));
                ptr_adv++;
            end
            ptr_prev = dut.ref_ptr;
        end
    end

    task automatic issue(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                         input logic [7:0] exp_rd, input logic exp_err, input bit hold,
                         output int acc);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("req_accept_timeout", 32'(req_ready), 32'd1);
        else exp_q.push_back('{rd: exp_rd, err: exp_err, due: acc + 2});
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog_timeout actual=%0d required=<20000 cycles", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int c1, c2, d0, a0, t0, last, acc, found;

        // Reset held three cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_zero", 32'({req_ready, rsp_valid, rsp_rdata, rsp_err,
                                       cell_valid, decay_event, refresh_overrun}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        chk("cells_empty_after_reset", 32'(cell_valid), 32'd0);
        @(posedge clk); #1;

        // Write then read
        issue(1'b1, 2'd2, 8'hA5, 8'h00, 1'b0, 1'b0, acc);
        issue(1'b0, 2'd2, 8'h00, 8'hA5, 1'b0, 1'b0, acc);
        drain();

        // Decay without refresh
        do_reset(2);
        d0 = decay_cnt;
        issue(1'b1, 2'd1, 8'h3C, 8'h00, 1'b0, 1'b0, c1);
        while (cyc < c1 + 67) @(negedge clk);
        chk("decay_count", 32'(decay_cnt - d0), 32'd1);
        chk("decay_cycle", 32'(last_decay_cyc), 32'(c1 + 65));
        chk("cell1_decayed", 32'(cell_valid[1]), 32'd0);
        @(posedge clk); #1;
        issue(1'b0, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0, acc);
        drain();

        // Retention under refresh
        do_reset(2);
        refresh_en = 1'b1;
        issue(1'b1, 2'd0, 8'h11, 8'h00, 1'b0, 1'b0, acc);
        issue(1'b1, 2'd1, 8'h22, 8'h00, 1'b0, 1'b0, acc);
        issue(1'b1, 2'd2, 8'h33, 8'h00, 1'b0, 1'b0, acc);
        issue(1'b1, 2'd3, 8'h44, 8'h00, 1'b0, 1'b0, acc);
        d0 = decay_cnt;
        a0 = ptr_adv;
        repeat (500) @(posedge clk);
        #1;
        chk("retention_no_decay", 32'(decay_cnt - d0), 32'd0);
        chk("retention_all_valid", 32'(cell_valid), 32'hF);
        chk("retention_refresh_slots", 32'(ptr_adv - a0 >= 55), 32'd1);
        issue(1'b0, 2'd0, 8'h00, 8'h11, 1'b0, 1'b0, acc);
        issue(1'b0, 2'd1, 8'h00, 8'h22, 1'b0, 1'b0, acc);
        issue(1'b0, 2'd2, 8'h00, 8'h33, 1'b0, 1'b0, acc);
        issue(1'b0, 2'd3, 8'h00, 8'h44, 1'b0, 1'b0, acc);
        drain();
        chk("retention_no_overrun", 32'(refresh_overrun), 32'd0);

        // Contention: req_valid held high throughout
        do_reset(2);
        refresh_en = 1'b1;
        t0 = cyc;
        a0 = ptr_adv;
        last = -1;
        for (int k = 0; k < 12; k++) begin
            issue(1'b1, 2'(k), 8'(8'h40 + k), 8'h00, 1'b0, 1'b1, acc);
            if (last >= 0) chk("host_wait_le3", 32'(acc - last - 2 <= 3), 32'd1);
            last = acc;
            issue(1'b0, 2'(k), 8'h00, 8'(8'h40 + k), 1'b0, 1'b1, acc);
            if (last >= 0) chk("host_wait_le3", 32'(acc - last - 2 <= 3), 32'd1);
            last = acc;
        end
        req_valid = 1'b0;
        chk("contention_refreshes", 32'(ptr_adv - a0 >= (cyc - t0) / 8 - 1), 32'd1);
        drain();
        chk("contention_no_overrun", 32'(refresh_overrun), 32'd0);

        // Write lands on the decay edge
        do_reset(2);
        refresh_en = 1'b0;
        issue(1'b1, 2'd0, 8'h5A, 8'h00, 1'b0, 1'b0, c1);
        while (cyc < c1 + 63) @(negedge clk);
        @(posedge clk); #1;
        d0 = decay_cnt;
        issue(1'b1, 2'd0, 8'h6B, 8'h00, 1'b0, 1'b0, c2);
        chk("race_accept_cycle", 32'(c2), 32'(c1 + 64));
        repeat (3) @(negedge clk);
        chk("race_no_decay", 32'(decay_cnt - d0), 32'd0);
        chk("race_cell0_valid", 32'(cell_valid[0]), 32'd1);
        @(posedge clk); #1;
        issue(1'b0, 2'd0, 8'h00, 8'h6B, 1'b0, 1'b0, acc);
        drain();

        // Reset while in REF_SENSE
        refresh_en = 1'b1;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!req_ready) begin
                found = 1;
                break;
            end
        end
        chk("refresh_slot_seen", 32'(found), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        refresh_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_ready_idle", 32'(req_ready), 32'd1);
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        chk("abort_cells_cleared", 32'(cell_valid), 32'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
